// File: rtl/pe_sequential_divider_pkg.sv
// Shared types and helpers for the PE sequential restoring divider.
package pe_sequential_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must be able to represent 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int divisor_width = 8
) (
  input  logic [divisor_width:0]   pr,
  input  logic                     dvd_bit,
  input  logic [divisor_width-1:0] divisor,
  output logic [divisor_width:0]   pr_next,
  output logic                     q_bit
);

  logic [divisor_width:0] shifted;
  logic [divisor_width:0] dsr_ext;

  always_comb begin
    shifted = {pr[divisor_width-1:0], dvd_bit};
    dsr_ext = {1'b0, divisor};
    q_bit   = (shifted >= dsr_ext);
    pr_next = q_bit ? (shifted - dsr_ext) : shifted;
  end

endmodule

// File: rtl/pe_sequential_divider.sv
// Multi-cycle unsigned radix-2 restoring divider with start/done handshake.
// Optional zero-divisor fast path when PE_DIV_ZERO_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | resolving one quotient bit per clock
// DONE  | results valid for one cycle; start here chains the next operation
module pe_sequential_divider
  import pe_sequential_divider_pkg::*;
#(
  parameter int dividend_width = 8,
  parameter int divisor_width  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [dividend_width-1:0] quotient,
  output logic [divisor_width-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int N  = dividend_width;
  localparam int M  = divisor_width;
  localparam int CW = cnt_width(N);

  div_state_t      state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    dvd;
  logic [M-1:0]    dsr;
  logic [M:0]      pr;
  logic [M:0]      pr_next;
  logic            q_bit;
  logic [N-1:0]    dvd_shift;

  div_restore_step #(.divisor_width(M)) u_step (
    .pr      (pr),
    .dvd_bit (dvd[N-1]),
    .divisor (dsr),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits fill in from the bottom.
  assign dvd_shift = (dvd << 1) | N'(q_bit);

`ifdef PE_DIV_ZERO_CHECK_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      pr        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef PE_DIV_ZERO_CHECK_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd <= dividend;
            dsr <= divisor;
            pr  <= '0;
            cnt <= '0;
`ifdef PE_DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= M'(dividend);
              dbz_q     <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          dvd <= dvd_shift;
          pr  <= pr_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dvd_shift;
            remainder <= pr_next[M-1:0];
`ifdef PE_DIV_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
